// File: rtl/mantissa_normalizer_pipe.sv
// mantissa_normalizer_pipe
//   Two-stage valid/ready post-add normaliser for the floating adder.
//   Stage 1 registers the raw adder result together with its leading-zero
//   count; stage 2 (the output register) holds the normalised fraction,
//   the adjusted exponent and the zero/underflow/overflow flags.
//   Optional build macro: NORM_ROUND_EN (round-to-nearest-even on the
//   carry path; truncation when undefined).
module mantissa_normalizer_pipe #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_carry,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    input  logic              in_sticky,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-2:0] out_frac,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_zero,
    output logic              out_uflow,
    output logic              out_oflow
);

    localparam int FW   = MANT_W - 1;
    localparam int LZ_W = $clog2(MANT_W + 1);
    // Exponent maths width: wide enough for EXP_W+1 bits and for the lz count.
    localparam int CW   = (LZ_W > EXP_W + 1) ? LZ_W : EXP_W + 1;
    localparam logic [EXP_W-1:0] EXP_ONES   = {EXP_W{1'b1}};
    localparam logic [CW-1:0]    EXP_ONES_C = CW'(EXP_ONES);

    // Leading-zero count: the highest set bit wins, MANT_W when no bit is set.
    function automatic logic [LZ_W-1:0] lzc(input logic [MANT_W-1:0] m);
        logic [LZ_W-1:0] n;
        n = LZ_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (m[i]) begin
                n = LZ_W'(MANT_W - 1 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Stage 1 registers
    logic              s1_valid_r;
    logic [MANT_W-1:0] s1_mant_r;
    logic              s1_carry_r;
    logic [EXP_W-1:0]  s1_exp_r;
    logic              s1_sign_r;
    logic [LZ_W-1:0]   s1_lz_r;

    // Handshake and stage 2 combinational results
    logic              s2_advance_s;
    logic [CW-1:0]     exp_c_s;
    logic [CW-1:0]     lz_c_s;
    logic [CW-1:0]     exp_inc_s;
    logic [FW-1:0]     carry_frac_s;
    logic [CW-1:0]     carry_exp_s;
    logic [FW-1:0]     nxt_frac_s;
    logic [EXP_W-1:0]  nxt_exp_s;
    logic              nxt_zero_s;
    logic              nxt_uflow_s;
    logic              nxt_oflow_s;

    assign s2_advance_s = ~out_valid | out_ready;
    assign in_ready     = ~s1_valid_r | s2_advance_s;

    assign exp_c_s   = CW'(s1_exp_r);
    assign lz_c_s    = CW'(s1_lz_r);
    assign exp_inc_s = exp_c_s + CW'(1);

`ifdef NORM_ROUND_EN
    logic              s1_sticky_r;
    logic              round_up_s;
    logic [MANT_W-1:0] rnd_sum_s;
    // Guard is the bit shifted out by the carry right-shift.
    assign round_up_s = s1_mant_r[0] & (s1_sticky_r | s1_mant_r[1]);
    assign rnd_sum_s  = {1'b0, s1_mant_r[MANT_W-1:1]} + MANT_W'(1);

    // Sticky only matters for rounding, so it is only staged in this build.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sticky_r <= 1'b0;
        end else if (in_ready && in_valid) begin
            s1_sticky_r <= in_sticky;
        end
    end
`else
    logic unused_sticky_s;
    assign unused_sticky_s = in_sticky;
`endif

    // Stage 1: capture the beat and its leading-zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_mant_r  <= {MANT_W{1'b0}};
            s1_carry_r <= 1'b0;
            s1_exp_r   <= {EXP_W{1'b0}};
            s1_sign_r  <= 1'b0;
            s1_lz_r    <= {LZ_W{1'b0}};
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_mant_r  <= in_mant;
                s1_carry_r <= in_carry;
                s1_exp_r   <= in_exp;
                s1_sign_r  <= in_sign;
                s1_lz_r    <= lzc(in_mant);
            end
        end
    end

    // Stage 2 datapath: carry shift, zero, underflow flush or left normalise.
    always_comb begin
        nxt_frac_s   = {FW{1'b0}};
        nxt_exp_s    = {EXP_W{1'b0}};
        nxt_zero_s   = 1'b0;
        nxt_uflow_s  = 1'b0;
        nxt_oflow_s  = 1'b0;
        carry_frac_s = s1_mant_r[MANT_W-1:1];
        carry_exp_s  = exp_inc_s;
`ifdef NORM_ROUND_EN
        if (round_up_s) begin
            if (rnd_sum_s[MANT_W-1]) begin
                carry_frac_s = {FW{1'b0}};
                carry_exp_s  = exp_inc_s + CW'(1);
            end else begin
                carry_frac_s = rnd_sum_s[FW-1:0];
                carry_exp_s  = exp_inc_s;
            end
        end else begin
            carry_frac_s = s1_mant_r[MANT_W-1:1];
            carry_exp_s  = exp_inc_s;
        end
`endif
        if (s1_carry_r) begin
            if (carry_exp_s >= EXP_ONES_C) begin
                nxt_oflow_s = 1'b1;
                nxt_exp_s   = EXP_ONES;
                nxt_frac_s  = {FW{1'b0}};
            end else begin
                nxt_frac_s  = carry_frac_s;
                nxt_exp_s   = EXP_W'(carry_exp_s);
            end
        end else if (s1_mant_r == {MANT_W{1'b0}}) begin
            nxt_zero_s  = 1'b1;
        end else if (lz_c_s >= exp_c_s) begin
            nxt_zero_s  = 1'b1;
            nxt_uflow_s = 1'b1;
        end else begin
            nxt_frac_s  = FW'(s1_mant_r << s1_lz_r);
            nxt_exp_s   = EXP_W'(exp_c_s - lz_c_s);
        end
    end

    // Stage 2 output register: load when empty or when downstream takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_frac  <= {FW{1'b0}};
            out_exp   <= {EXP_W{1'b0}};
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
            out_oflow <= 1'b0;
        end else if (s2_advance_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_frac  <= nxt_frac_s;
                out_exp   <= nxt_exp_s;
                out_sign  <= s1_sign_r;
                out_zero  <= nxt_zero_s;
                out_uflow <= nxt_uflow_s;
                out_oflow <= nxt_oflow_s;
            end
        end
    end

endmodule

// File: tb/tb_mantissa_normalizer_pipe.sv
// tb_mantissa_normalizer_pipe
//   Directed spec vectors, backpressure, reset mid-stream and a random run
//   against an arithmetic reference model (MANT_W=24, EXP_W=8).
module tb_mantissa_normalizer_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_mant;
    logic        in_carry;
    logic [7:0]  in_exp;
    logic        in_sign;
    logic        in_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] out_frac;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic        out_zero;
    logic        out_uflow;
    logic        out_oflow;

    int total  = 0;
    int passed = 0;

    logic [34:0] exp_q[$];
    logic        have_beat;
    logic [23:0] b_mant;
    logic        b_carry;
    logic [7:0]  b_exp;
    logic        b_sign;
    logic        b_sticky;

    mantissa_normalizer_pipe #(.MANT_W(24), .EXP_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_carry(in_carry), .in_exp(in_exp),
        .in_sign(in_sign), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_frac(out_frac), .out_exp(out_exp), .out_sign(out_sign),
        .out_zero(out_zero), .out_uflow(out_uflow), .out_oflow(out_oflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Reference: {frac[22:0], exp[7:0], sign, zero, uflow, oflow}
    function automatic logic [34:0] model(input logic [23:0] m, input logic c,
                                          input logic [7:0] e, input logic s,
                                          input logic st);
        int mi, f, x, lz;
        logic z, u, o;
        mi = int'(m);
        f = 0; x = 0; z = 1'b0; u = 1'b0; o = 1'b0;
        if (c) begin
            f = mi / 2;
            x = int'(e) + 1;
`ifdef NORM_ROUND_EN
            if ((mi % 2 == 1) && (st || (f % 2 == 1))) f = f + 1;
            if (f == (1 << 23)) begin
                f = 0;
                x = x + 1;
            end
`endif
            if (x >= 255) begin
                o = 1'b1; x = 255; f = 0;
            end
        end else if (mi == 0) begin
            z = 1'b1;
        end else begin
            lz = 24 - $clog2(mi + 1);
            if (lz >= int'(e)) begin
                z = 1'b1; u = 1'b1;
            end else begin
                f = (mi << lz) % (1 << 23);
                x = int'(e) - lz;
            end
        end
        return {f[22:0], x[7:0], s, z, u, o};
    endfunction

    function automatic logic [34:0] out_vec();
        return {out_frac, out_exp, out_sign, out_zero, out_uflow, out_oflow};
    endfunction

    task automatic gen_beat();
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0: b_mant = 24'h000000;
            1: b_mant = 24'h800000 | 24'($urandom());
            default: b_mant = 24'($urandom() >> $urandom_range(8, 31));
        endcase
        sel = $urandom_range(0, 3);
        case (sel)
            0: b_exp = 8'($urandom_range(0, 30));
            1: b_exp = 8'($urandom_range(248, 254));
            default: b_exp = 8'($urandom_range(0, 254));
        endcase
        b_carry   = ($urandom_range(0, 3) == 0);
        b_sign    = 1'($urandom_range(0, 1));
        b_sticky  = 1'($urandom_range(0, 1));
        have_beat = 1'b1;
    endtask

    // One clock: drive, check the visible output against the scoreboard, account transfers.
    task automatic cycle(input logic ordy);
        logic acc_in, acc_out;
        in_valid  = have_beat;
        in_mant   = b_mant;
        in_carry  = b_carry;
        in_exp    = b_exp;
        in_sign   = b_sign;
        in_sticky = b_sticky;
        out_ready = ordy;
        #4;
        acc_in  = in_valid & in_ready;
        acc_out = out_valid & out_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) chk("spurious_beat", 64'(out_valid), 64'(0));
            else chk("beat", 64'(out_vec()), 64'(exp_q[0]));
        end
        if (acc_out && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc_in) begin
            exp_q.push_back(model(b_mant, b_carry, b_exp, b_sign, b_sticky));
            have_beat = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipe; checks 2-cycle latency and a constant expectation.
    task automatic directed(input string tag, input logic [23:0] m, input logic c,
                            input logic [7:0] e, input logic s, input logic st,
                            input logic [34:0] expv);
        in_valid = 1'b1; in_mant = m; in_carry = c; in_exp = e;
        in_sign = s; in_sticky = st; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #4;
        chk({tag, "_early"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_data"}, 64'(out_vec()), 64'(expv));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mant = 24'h0; in_carry = 1'b0;
        in_exp = 8'h0; in_sign = 1'b0; in_sticky = 1'b0; out_ready = 1'b0;
        have_beat = 1'b0; b_mant = 24'h0; b_carry = 1'b0; b_exp = 8'h0;
        b_sign = 1'b0; b_sticky = 1'b0;
        #12;
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_outs", 64'(out_vec()), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        directed("norm_msb", 24'h800000, 1'b0, 8'h7F, 1'b0, 1'b0, {23'h0, 8'h7F, 4'b0000});
        directed("lz23",     24'h000001, 1'b0, 8'h80, 1'b0, 1'b0, {23'h0, 8'h69, 4'b0000});
`ifdef NORM_ROUND_EN
        directed("carry3",   24'h000003, 1'b1, 8'h7F, 1'b0, 1'b0, {23'h2, 8'h80, 4'b0000});
        directed("carry_ff", 24'hFFFFFF, 1'b1, 8'h10, 1'b0, 1'b1, {23'h0, 8'h12, 4'b0000});
`else
        directed("carry3",   24'h000003, 1'b1, 8'h7F, 1'b0, 1'b0, {23'h1, 8'h80, 4'b0000});
        directed("carry_ff", 24'hFFFFFF, 1'b1, 8'h10, 1'b0, 1'b1, {23'h7FFFFF, 8'h11, 4'b0000});
`endif
        directed("oflow",    24'h123456, 1'b1, 8'hFE, 1'b0, 1'b0, {23'h0, 8'hFF, 4'b0001});
        directed("uflow",    24'h000100, 1'b0, 8'h05, 1'b1, 1'b0, {23'h0, 8'h00, 4'b1110});
        directed("zero",     24'h000000, 1'b0, 8'h40, 1'b1, 1'b0, {23'h0, 8'h00, 4'b1100});
        directed("lz_eq_e",  24'h000100, 1'b0, 8'h0F, 1'b0, 1'b0, {23'h0, 8'h00, 4'b0110});
        directed("lz_lt_e",  24'h000100, 1'b0, 8'h10, 1'b0, 1'b0, {23'h0, 8'h01, 4'b0000});
        directed("lz1",      24'h400001, 1'b0, 8'h10, 1'b0, 1'b0, {23'h2, 8'h0F, 4'b0000});

        // Backpressure: 4 back-to-back beats, out_ready low for the first 3 cycles.
        begin
            int sent;
            sent = 0;
            for (int cyc = 0; cyc < 16; cyc++) begin
                if (!have_beat && sent < 4) begin
                    gen_beat();
                    sent++;
                end
                if (cyc == 2) begin
                    out_ready = 1'b0;
                    #1;
                    chk("bp_in_ready", 64'(in_ready), 64'(0));
                end
                cycle(cyc < 3 ? 1'b0 : 1'b1);
            end
            chk("bp_all_sent", 64'(sent), 64'(4));
            chk("bp_drained", 64'(exp_q.size()), 64'(0));
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            if (!have_beat && $urandom_range(0, 3) != 0) gen_beat();
            cycle($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() != 0 || have_beat) cycle(1'b1);
        end
        chk("rand_drained", 64'(exp_q.size()), 64'(0));

        // Reset mid-stream with two beats in flight.
        gen_beat(); cycle(1'b1);
        gen_beat(); cycle(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(out_valid), 64'(0));
        chk("mid_reset_outs", 64'(out_vec()), 64'(0));
        exp_q.delete();
        have_beat = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        #2;
        for (int i = 0; i < 6; i++) begin
            chk("post_reset_valid", 64'(out_valid), 64'(0));
            cycle(1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
